cross_arbiter: RTL
==================

# cross_arbiter

Round-robin arbiter sharing one `Cross` unit (FIFO-wrapped cross product) among `NUM_REQ` requesters. It pops operand pairs from requester input FIFOs and pushes them into the shared unit's input side. Each issue is tagged with its requester index. Results popped from the unit's output FIFO are steered back to the originating requester's response FIFO, in issue order. It sits between the ray/triangle setup stages and the single shared `Cross` instance.

## Interface

- `NUM_REQ`, 2: requester count, legal 2..4.
- `TAG_DEPTH`, 8: tag FIFO depth, power of two; caps in-flight operations.
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `req_empty` in [NUM_REQ]: requester operand FIFO empty; first-word fall-through.
- `req_rd_en` out [NUM_REQ]: one-hot pop strobe.
- `req_x`, `req_y` in [NUM_REQ][3][32] signed: requester operand vectors.
- `cu_full` in 1: shared unit input full.
- `cu_wr_en` out 1: push strobe to the shared unit.
- `cu_x`, `cu_y` out [3][32] signed: registered operands.
- `cu_empty` in 1: shared unit output FIFO empty; fall-through.
- `cu_rd_en` out 1: pop strobe for the shared unit output.
- `cu_dout` in [3][32] signed: shared unit result.
- `rsp_full` in [NUM_REQ]: response FIFO full, per requester.
- `rsp_wr_en` out [NUM_REQ]: one-hot response push.
- `rsp_dout` out [3][32] signed: registered result, broadcast to all response FIFOs.
- `tag_count` out [$clog2(TAG_DEPTH)+1]: operations in flight.
- `tag_err` out 1: sticky error; a result arrived with no tag outstanding.

## Operation

- **Issue FSM, state `I_ARB`**
  - Grant `g` is the first index at or after `rr_ptr` (modulo `NUM_REQ`) with `req_empty[g]==0`.
  - If a grant exists and the tag FIFO is not full:
    - `req_rd_en[g]=1`.
    - Latch `req_x[g]` and `req_y[g]` into `cu_x` and `cu_y`.
    - Push `g` into the tag FIFO.
    - Go to `I_PUSH`.
- **Issue FSM, state `I_PUSH`**
  - If `cu_full==0`: `cu_wr_en=1`, `rr_ptr<=(g+1)%NUM_REQ`, go to `I_ARB`.
  - Otherwise hold; `cu_x` and `cu_y` stay stable.
- **Return FSM, state `R_IDLE`**
  - If `cu_empty==0` and tag FIFO not empty: `cu_rd_en=1`, `rsp_dout<=cu_dout`, pop tag into `r_tag`, go to `R_WRITE`.
  - If `cu_empty==0` and tag FIFO empty: set `tag_err`, do not pop.
- **Return FSM, state `R_WRITE`**
  - If `rsp_full[r_tag]==0`: `rsp_wr_en[r_tag]=1`, go to `R_IDLE`.
  - Otherwise hold.
- Strobes are combinational from state and inputs. They are forced to 0 while `reset` is high.
- Tag push and pop in the same cycle are both honoured; `tag_count` is unchanged.
- Arbitration is blocked when `tag_count==TAG_DEPTH`.
- The unit is never pushed more than `TAG_DEPTH` operations ahead of the return side.
- No arithmetic is done here. Operand and result vectors pass through bit-exact.
- `tag_err` clears only on reset.

## Timing

- Reset values: `cu_x`, `cu_y`, `rsp_dout` = 0; `rr_ptr`=0; `tag_count`=0; `tag_err`=0.
- Reset states: `I_ARB` and `R_IDLE`. All strobes are 0.
- Issue takes 2 cycles minimum per op: pop in cycle n, `cu_wr_en` in cycle n+1.
- Return takes 2 cycles minimum per result: `cu_rd_en` in cycle m, `rsp_wr_en` in cycle m+1.
- The issue and return FSMs run concurrently and independently.
- A requester whose response FIFO is full stalls the return path for all requesters. Ordering is strict.
- A single requester with continuous data gets every grant.
- Reset asserted mid-operation:
  - In-flight tags are discarded.
  - FSMs return to `I_ARB` and `R_IDLE` on the next edge.
  - The shared unit shares `reset` and is flushed with the arbiter.

## Configuration

- `CROSS_ARBITER_STATS_EN` defined:
  - Adds output `issue_cnt` [NUM_REQ][16].
  - Each element increments on every `cu_wr_en` for that requester.
  - Counters wrap 0xFFFF→0 and reset to 0.
- Undefined: the port and counters are absent. Behaviour is otherwise identical.

## Structure

- Package `cross_arbiter_pkg` holds:
  - `vec3_t` (signed [2:0][31:0]).
  - Issue and return FSM state enums.
  - `TAG_W` constant function.
- Sub-module `cross_tag_fifo`:
  - Synchronous FIFO of `TAG_W`-bit tags, depth `TAG_DEPTH`.
  - Wrapping pointers.
  - Outputs `full`, `empty` and `count`.

## Test plan

- **Single op.** Requester 1 supplies x=(1024,0,0), y=(0,1024,0) through `Cross` with Q_BITS=10. Expect `rsp_wr_en[1]` only, `rsp_dout`=(0,0,1024), `tag_count` back to 0.
- **Round-robin.** Both requesters hold 4 ops each. Expect `cu_wr_en` tags to alternate 0,1,0,1..., and each response FIFO to receive exactly 4 results, in order.
- **Tag full.** Hold `cu_empty=1`, NUM_REQ=2, TAG_DEPTH=8, 10 ops queued. Expect exactly 8 `req_rd_en` pulses and `tag_count=8`. Issue resumes after the first return.
- **Backpressure.** Hold `rsp_full[0]=1` with ops from both requesters. Expect the return FSM parked in `R_WRITE` and no `rsp_wr_en`. Releasing it drains in issue order.
- **Orphan result.** Force `cu_empty=0` with the tag FIFO empty. Expect `tag_err=1`, `cu_rd_en=0`, and the error sticky until reset.
- **Mid-operation reset.** Assert `reset` with 3 ops in flight. Next cycle expect `tag_count=0`, all strobes 0 and `rr_ptr=0`. With `CROSS_ARBITER_STATS_EN` defined, also expect `issue_cnt=0`.

Source files
------------

// File: rtl/cross_arbiter_pkg.sv
// Shared types for the cross-product arbiter: operand vector, FSM states, tag width.
package cross_arbiter_pkg;

  typedef logic signed [2:0][31:0] vec3_t;

  typedef enum logic {I_ARB, I_PUSH} istate_t;
  typedef enum logic {R_IDLE, R_WRITE} rstate_t;

  // Tag wide enough to name any requester; never narrower than one bit.
  function automatic int TAG_W(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/cross_arbiter_if.sv
// Requester, shared-unit and response FIFO handshakes seen by the arbiter.
interface cross_arbiter_if #(parameter int NUM_REQ = 2);

  logic [NUM_REQ-1:0]          req_empty;
  logic [NUM_REQ-1:0]          req_rd_en;
  cross_arbiter_pkg::vec3_t    req_x [NUM_REQ];
  cross_arbiter_pkg::vec3_t    req_y [NUM_REQ];
  logic                        cu_full;
  logic                        cu_wr_en;
  cross_arbiter_pkg::vec3_t    cu_x;
  cross_arbiter_pkg::vec3_t    cu_y;
  logic                        cu_empty;
  logic                        cu_rd_en;
  cross_arbiter_pkg::vec3_t    cu_dout;
  logic [NUM_REQ-1:0]          rsp_full;
  logic [NUM_REQ-1:0]          rsp_wr_en;
  cross_arbiter_pkg::vec3_t    rsp_dout;

  modport master (
    input  req_empty, req_x, req_y, cu_full, cu_empty, cu_dout, rsp_full,
    output req_rd_en, cu_wr_en, cu_x, cu_y, cu_rd_en, rsp_wr_en, rsp_dout
  );

  modport slave (
    output req_empty, req_x, req_y, cu_full, cu_empty, cu_dout, rsp_full,
    input  req_rd_en, cu_wr_en, cu_x, cu_y, cu_rd_en, rsp_wr_en, rsp_dout
  );

endinterface

// File: rtl/cross_tag_fifo.sv
// Synchronous tag FIFO with wrapping pointers; dout shows the head entry (fall-through).
module cross_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/cross_arbiter.sv
// Round-robin sharing of one Cross unit; results return to their requester in issue order.
// Optional per-requester issue counters under CROSS_ARBITER_STATS_EN.
module cross_arbiter
  import cross_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int TAG_DEPTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  cross_arbiter_if.master              bus,
  output logic [$clog2(TAG_DEPTH):0]   tag_count,
  output logic                         tag_err
`ifdef CROSS_ARBITER_STATS_EN
  ,
  output logic [15:0]                  issue_cnt [NUM_REQ]
`endif
);

  localparam int TW = TAG_W(NUM_REQ);
  localparam logic [TW-1:0] LAST = TW'(NUM_REQ - 1);

  istate_t       istate;
  rstate_t       rstate;
  logic [TW-1:0] rr_ptr;
  logic [TW-1:0] gnt;
  logic [TW-1:0] gnt_q;
  logic [TW-1:0] cand;
  logic [TW-1:0] r_tag;
  logic [TW-1:0] tag_dout;
  logic          gnt_vld;
  logic          tag_full;
  logic          tag_empty;
  logic          issue_go;
  logic          ret_go;

  // Scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = TW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!bus.req_empty[cand]) begin
        gnt     = cand;
        gnt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    issue_go      = !reset && (istate == I_ARB) && gnt_vld && !tag_full;
    ret_go        = !reset && (rstate == R_IDLE) && !bus.cu_empty && !tag_empty;
    bus.req_rd_en = '0;
    if (issue_go) bus.req_rd_en[gnt] = 1'b1;
    bus.cu_wr_en  = !reset && (istate == I_PUSH) && !bus.cu_full;
    bus.cu_rd_en  = ret_go;
    bus.rsp_wr_en = '0;
    if (!reset && (rstate == R_WRITE) && !bus.rsp_full[r_tag]) bus.rsp_wr_en[r_tag] = 1'b1;
  end

  cross_tag_fifo #(.DEPTH(TAG_DEPTH), .W(TW)) u_tags (
    .clock (clock),
    .reset (reset),
    .push  (issue_go),
    .pop   (ret_go),
    .din   (gnt),
    .dout  (tag_dout),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      istate     <= I_ARB;
      rr_ptr     <= '0;
      gnt_q      <= '0;
      bus.cu_x   <= '0;
      bus.cu_y   <= '0;
    end else begin
      case (istate)
        I_ARB: if (issue_go) begin
          bus.cu_x <= bus.req_x[gnt];
          bus.cu_y <= bus.req_y[gnt];
          gnt_q    <= gnt;
          istate   <= I_PUSH;
        end
        I_PUSH: if (!bus.cu_full) begin
          rr_ptr <= (gnt_q == LAST) ? '0 : gnt_q + TW'(1);
          istate <= I_ARB;
        end
        default: istate <= I_ARB;
      endcase
    end
  end

  // An orphan result is flagged but left in the unit; the error stays until reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      rstate       <= R_IDLE;
      r_tag        <= '0;
      bus.rsp_dout <= '0;
      tag_err      <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (ret_go) begin
            bus.rsp_dout <= bus.cu_dout;
            r_tag        <= tag_dout;
            rstate       <= R_WRITE;
          end else if (!bus.cu_empty && tag_empty) begin
            tag_err <= 1'b1;
          end
        end
        R_WRITE: if (!bus.rsp_full[r_tag]) rstate <= R_IDLE;
        default: rstate <= R_IDLE;
      endcase
    end
  end

`ifdef CROSS_ARBITER_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) issue_cnt[i] <= '0;
    end else if (bus.cu_wr_en) begin
      issue_cnt[gnt_q] <= issue_cnt[gnt_q] + 16'd1;
    end
  end
`endif

endmodule
